// File: rtl/fibo_controller.sv
// Moore control FSM for a Fibonacci datapath: seeds R0/R1, then walks a
// 4-entry circular register file adding the two previous terms n times.
module fibo_controller #(
   parameter int SIZE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SIZE-1:0]   n,
   input  logic              zero_flag,
   output logic [SIZE-3:0]   wrt_addr,
   output logic              wrt_en,
   output logic              load_data,
   output logic [SIZE-3:0]   rd_addr1,
   output logic [SIZE-3:0]   rd_addr2,
   output logic [SIZE-2:0]   alu_opcode,
   output logic [SIZE-1:0]   count,
   output logic              busy,
   output logic              done,
   output logic              zero_seen
);

   localparam int ADDR_W = SIZE - 2;
   localparam int OP_W   = SIZE - 1;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LD0  = 3'd1;
   localparam logic [2:0] LD1  = 3'd2;
   localparam logic [2:0] ADD  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [OP_W-1:0] OP_PASS = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6);

   logic [2:0]        state_reg;
   logic [ADDR_W-1:0] ptr_reg;
   logic [SIZE-1:0]   remaining_reg;
   logic [ADDR_W-1:0] last_addr_reg;
   logic              zero_seen_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= ADDR_W'(2);
         remaining_reg <= '0;
         last_addr_reg <= '0;
         zero_seen_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  remaining_reg <= n;
                  ptr_reg       <= ADDR_W'(2);
                  zero_seen_reg <= 1'b0;
                  state_reg     <= LD0;
               end
            end
            LD0: begin
               last_addr_reg <= '0;
               state_reg     <= LD1;
            end
            LD1: begin
               last_addr_reg <= ADDR_W'(1);
               state_reg     <= (remaining_reg == '0) ? DONE : ADD;
            end
            ADD: begin
               // ptr wraps naturally at the register-file depth
               last_addr_reg <= ptr_reg;
               ptr_reg       <= ptr_reg + ADDR_W'(1);
               remaining_reg <= remaining_reg - SIZE'(1);
               if (zero_flag)
                  zero_seen_reg <= 1'b1;
               if (remaining_reg == SIZE'(1))
                  state_reg <= DONE;
            end
            DONE: state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      wrt_addr   = '0;
      wrt_en     = 1'b0;
      load_data  = 1'b0;
      rd_addr1   = '0;
      rd_addr2   = '0;
      alu_opcode = '0;
      count      = '0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: rd_addr1 = last_addr_reg;
         LD0: begin
            wrt_en     = 1'b1;
            load_data  = 1'b1;
            alu_opcode = OP_PASS;
            busy       = 1'b1;
         end
         LD1: begin
            wrt_addr   = ADDR_W'(1);
            wrt_en     = 1'b1;
            load_data  = 1'b1;
            count      = SIZE'(1);
            alu_opcode = OP_PASS;
            busy       = 1'b1;
         end
         ADD: begin
            wrt_addr   = ptr_reg;
            rd_addr1   = ptr_reg - ADDR_W'(1);
            rd_addr2   = ptr_reg - ADDR_W'(2);
            wrt_en     = 1'b1;
            alu_opcode = OP_ADD;
            busy       = 1'b1;
         end
         DONE: begin
            rd_addr1 = last_addr_reg;
            busy     = 1'b1;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

   assign zero_seen = zero_seen_reg;

endmodule

// File: tb/tb_fibo_controller.sv
// Bench for fibo_controller: a small datapath model closes the loop, and a
// cycle-indexed Fibonacci reference predicts every output cycle by cycle.
module tb_fibo_controller;
   localparam int SIZE = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] n;
   logic       zero_flag;
   logic [1:0] wrt_addr, rd_addr1, rd_addr2;
   logic       wrt_en, load_data, busy, done, zero_seen;
   logic [2:0] alu_opcode;
   logic [3:0] count;

   always #5 clk = ~clk;

   fibo_controller #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst), .start(start), .n(n), .zero_flag(zero_flag),
      .wrt_addr(wrt_addr), .wrt_en(wrt_en), .load_data(load_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .alu_opcode(alu_opcode),
      .count(count), .busy(busy), .done(done), .zero_seen(zero_seen)
   );

   // datapath: 4-entry register file plus pass/add ALU
   logic [3:0] rf [4];
   logic [3:0] alu_res, wdata;
   always_comb begin
      alu_res = 4'd0;
      if (alu_opcode == 3'b110)      alu_res = rf[rd_addr1] + rf[rd_addr2];
      else if (alu_opcode == 3'b001) alu_res = rf[rd_addr1];
      wdata = load_data ? count : alu_res;
   end
   assign zero_flag = (alu_res == 4'd0);
   always @(posedge clk) if (wrt_en) rf[wrt_addr] <= wdata;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference: cycle index since acceptance (0 = idle), Fibonacci terms mod 16
   int fib [20];
   int cyc = 0, mn = 0, m_last = 0;
   bit m_zs = 0;
   int tcnt = 0, acc_t = 0, lat = 0, done_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc = 0; m_last = 0; m_zs = 0;
      end else begin
         tcnt++;
         if (cyc == 0) begin
            if (start) begin
               cyc = 1; mn = int'(n); m_zs = 0; acc_t = tcnt;
            end
         end else begin
            if (cyc == 1) m_last = 0;
            else if (cyc == 2) m_last = 1;
            else if (cyc <= mn + 2) begin
               m_last = (cyc - 1) % 4;
               if (fib[cyc-1] == 0) m_zs = 1;
            end
            if (cyc == mn + 3) cyc = 0;
            else cyc++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs",
             {30'd0, wrt_en, busy} | {31'd0, done} | {31'd0, load_data} | {31'd0, zero_seen}
             | {28'd0, count} | {29'd0, alu_opcode} | {30'd0, wrt_addr}
             | {30'd0, rd_addr1} | {30'd0, rd_addr2}, 0);
      end else begin
         if (cyc == 0 || cyc == mn + 3) begin
            chk("busy", busy, cyc != 0);
            chk("done", done, cyc != 0);
            chk("wrt_en", wrt_en, 0);
            chk("rd_addr1_last", rd_addr1, m_last);
         end else begin
            chk("busy", busy, 1);
            chk("done", done, 0);
            chk("wrt_en", wrt_en, 1);
            chk("load_data", load_data, cyc <= 2);
            chk("alu_opcode", alu_opcode, (cyc <= 2) ? 1 : 6);
            chk("wrt_addr", wrt_addr, (cyc == 1) ? 0 : (cyc == 2) ? 1 : (cyc - 1) % 4);
            chk("wdata", wdata, (cyc == 1) ? 0 : (cyc == 2) ? 1 : fib[cyc-1]);
         end
         chk("zero_seen", zero_seen, m_zs);
         if (done) begin
            lat = tcnt - acc_t + 1;
            done_cnt++;
         end
      end
   end

   task automatic run(input int nn, input int hold);
      @(posedge clk); #2;
      start = 1'b1; n = 4'(nn);
      repeat (hold) @(posedge clk);
      #2 start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      $display("run n=%0d hold=%0d latency=%0d zero_seen=%0b", nn, hold, lat, zero_seen);
   endtask

   initial begin
      int d0;
      fib[0] = 0; fib[1] = 1;
      for (int i = 2; i < 20; i++) fib[i] = (fib[i-1] + fib[i-2]) % 16;
      for (int i = 0; i < 4; i++) rf[i] = 4'd0;
      rst = 1'b1; start = 1'b0; n = 4'd0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      chk("reset_busy", busy, 0);

      run(3, 1);
      chk("n3_lat", lat, 6);
      chk("n3_R0", rf[0], 3); chk("n3_R1", rf[1], 1);
      chk("n3_R2", rf[2], 1); chk("n3_R3", rf[3], 2);
      chk("n3_idle_rd", rf[rd_addr1], 3);

      run(0, 1);
      chk("n0_lat", lat, 3);
      chk("n0_R0", rf[0], 0); chk("n0_R1", rf[1], 1);
      chk("n0_rd1", rd_addr1, 1);

      run(11, 1);
      chk("n11_lat", lat, 14);
      chk("n11_zero_seen", zero_seen, 1);
      run(2, 1);
      chk("n2_zero_cleared", zero_seen, 0);

      run(15, 1);
      chk("n15_lat", lat, 18);
      chk("n15_zero_seen", zero_seen, 1);

      d0 = done_cnt;
      run(2, 8);
      chk("held_start_runs", done_cnt - d0, 2);

      // abort during the second ADD cycle
      @(posedge clk); #2 start = 1'b1; n = 4'd5;
      @(posedge clk); #2 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_wrt_en", wrt_en, 0);
      chk("async_busy", busy, 0);
      chk("async_wrt_addr", wrt_addr, 0);
      chk("async_opcode", alu_opcode, 0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      chk("post_abort_idle", busy, 0);
      $display("abort mid-ADD checked");

      for (int it = 0; it < 30; it++) begin
         int rn, rh, gap;
         rn = int'($urandom_range(0, 15));
         rh = int'($urandom_range(1, 3));
         gap = int'($urandom_range(0, 22));
         @(posedge clk); #2 start = 1'b1; n = 4'(rn);
         repeat (rh) @(posedge clk);
         #2 start = 1'b0;
         if ($urandom_range(0, 4) == 0) begin
            repeat (int'($urandom_range(0, 10))) @(posedge clk);
            #3 rst = 1'b1;
            @(posedge clk); #2 rst = 1'b0;
         end
         repeat (gap) @(posedge clk);
         #2;
         $display("rand it=%0d n=%0d hold=%0d gap=%0d busy=%0b", it, rn, rh, gap, busy);
      end
      repeat (22) @(posedge clk);
      #2;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fibo_controller.md
FIBO_CONTROLLER -- requirements
Module: fibo_controller

Interface
REQ-001: The block SHALL have parameter SIZE, default 4, giving the datapath word width; register address width is SIZE-2 and opcode width is SIZE-1.
REQ-002: Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003: Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004: Port start, input, 1 bit: request to run one sequence; sampled only in IDLE.
REQ-005: Port n, input, SIZE bits: number of terms to compute after the two seeds; captured when start is accepted.
REQ-006: Port zero_flag, input, 1 bit: datapath ALU-result-is-zero indication.
REQ-007: Port wrt_addr, output, SIZE-2 bits: datapath register-file write address.
REQ-008: Port wrt_en, output, 1 bit: datapath register-file write enable.
REQ-009: Port load_data, output, 1 bit: 1 selects count as write data; 0 selects the ALU result.
REQ-010: Ports rd_addr1 and rd_addr2, output, SIZE-2 bits each: datapath read addresses.
REQ-011: Port alu_opcode, output, SIZE-1 bits: 3'b001 = pass, 3'b110 = add.
REQ-012: Port count, output, SIZE bits: constant write data used during seed loads.
REQ-013: Ports busy, done, zero_seen, output, 1 bit each: sequence active, one-cycle completion pulse, sticky wrap-to-zero status.

Function
REQ-014: The block SHALL be a Moore FSM with states IDLE, LD0, LD1, ADD, DONE; all outputs are registered or decoded from state and registers only.
REQ-015: IDLE: wrt_en=0, busy=0; rd_addr1 = last written address; start=1 at a clock edge captures n into remaining, sets ptr=2, clears zero_seen, moves to LD0.
REQ-016: LD0: wrt_addr=0, wrt_en=1, load_data=1, count=0, alu_opcode=3'b001; always moves to LD1.
REQ-017: LD1: wrt_addr=1, wrt_en=1, load_data=1, count=1, alu_opcode=3'b001; moves to DONE if remaining==0, else ADD.
REQ-018: ADD: wrt_addr=ptr, rd_addr1=ptr-1, rd_addr2=ptr-2 (modulo 4), wrt_en=1, load_data=0, alu_opcode=3'b110; each edge increments ptr (3 wraps to 0) and decrements remaining; leaves for DONE at the edge where remaining==1.
REQ-019: The register file is used as a 4-entry circular buffer; the sum wraps modulo 2^SIZE with no carry output.
REQ-020: If zero_flag=1 at a rising edge while in ADD, zero_seen SHALL be set and hold until the next accepted start or reset.
REQ-021: DONE: wrt_en=0, done=1 for exactly one cycle, busy=1, rd_addr1 = last written address; always returns to IDLE.
REQ-022: busy SHALL be 1 in LD0, LD1, ADD, DONE; start asserted in those states is ignored and not queued.
REQ-023: Latency from the accepting edge to the done pulse SHALL be n+3 cycles: LD0, LD1, n ADD cycles, then DONE.
REQ-024: n=0 SHALL write only the seeds (LD0, LD1, DONE); n=2^SIZE-1 runs 15 ADD cycles with no early exit.

Reset
REQ-025: rst=1 SHALL immediately, without a clock, force IDLE, ptr=2, remaining=0, last address=0, and drive all outputs to 0.
REQ-026: rst asserted mid-sequence SHALL abort it with no further writes; after release the block waits in IDLE for a new start.

Verification
REQ-027: n=3, start pulse: wrt_addr sequence 0,1,2,3,0 with wrt_en=1; datapath R0..R3 end as 3,1,1,2; done high on the 6th cycle after acceptance; IDLE rd_addr1=0 shows data=3.
REQ-028: n=0: exactly two writes (R0=0, R1=1), done on the 3rd cycle, rd_addr1=1 in IDLE.
REQ-029: n=11 against the datapath: the last ADD writes F12 mod 16 = 0, so zero_flag=1 and zero_seen=1 after done; the next start clears zero_seen.
REQ-030: start held high throughout a run: no restart until IDLE, then a new sequence is accepted on the first IDLE edge.
REQ-031: rst pulsed during the 2nd ADD cycle: outputs go to 0 asynchronously, and no wrt_en occurs until a new start is accepted.
REQ-032: n=15: wrt_addr cycles 2,3,0,1 through the 15 ADD cycles, ptr wraps correctly, and done arrives 18 cycles after acceptance.
